// File: rtl/program_memory_loadable.sv
// Run-time loadable program memory for the 8-bit CPU.
// A host streams ADDR, LEN, LEN data bytes and CSUM over valid/ready.
// Fetch ports are combinational and return NOP_CODE until a checksum-verified image is resident.
module program_memory_loadable #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [DATA_W-1:0] NOP_CODE = 8'h70
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_data_next,
    output logic              cpu_hold,
    output logic              prog_valid,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_done,
    output logic              ld_error,
    output logic [ADDR_W:0]   ld_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  remain;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_fin;
    logic [ADDR_W-1:0] addr_next;
    logic              xfer;
    logic              wr_en;
    logic              csum_ok;
    logic [DATA_W-1:0] mem [DEPTH];

    // Handshake, checksum test and write enable; a byte arriving with ld_start is dropped.
    always_comb begin
        ld_ready = (state == S_ADDR) || (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
        xfer     = ld_valid && ld_ready;
        wr_en    = xfer && (state == S_DATA) && !ld_start && reset;
        sum_fin  = sum + ld_data;
        csum_ok  = (sum_fin == '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; ld_start overrides any transfer in progress.
    always_comb begin
        state_nx = state;
        if (ld_start) begin
            state_nx = S_ADDR;
        end else begin
            case (state)
                S_ADDR: if (xfer) state_nx = S_LEN;
                S_LEN:  if (xfer) state_nx = S_DATA;
                S_DATA: if (xfer && remain == CNT_W'(1)) state_nx = S_CSUM;
                S_CSUM: if (xfer) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Loader datapath: pointer, remaining length, running sum, status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prog_valid <= 1'b0;
            ld_done    <= 1'b0;
            ld_error   <= 1'b0;
            ld_count   <= '0;
            wr_ptr     <= '0;
            remain     <= '0;
            sum        <= '0;
        end else begin
            ld_done <= 1'b0;
            if (ld_start) begin
                prog_valid <= 1'b0;
                ld_error   <= 1'b0;
                ld_count   <= '0;
            end else if (xfer) begin
                case (state)
                    S_ADDR: wr_ptr <= ADDR_W'(ld_data);
                    S_LEN: begin
                        remain   <= (ld_data == '0) ? CNT_W'(DEPTH) : CNT_W'(ld_data);
                        sum      <= '0;
                        ld_count <= '0;
                    end
                    S_DATA: begin
                        wr_ptr   <= wr_ptr + ADDR_W'(1);
                        sum      <= sum_fin;
                        ld_count <= ld_count + CNT_W'(1);
                        remain   <= remain - CNT_W'(1);
                    end
                    S_CSUM: begin
                        if (csum_ok) begin
                            prog_valid <= 1'b1;
                            ld_done    <= 1'b1;
                            ld_error   <= 1'b0;
                        end else begin
                            ld_error   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory array; deliberately not cleared, stale words are masked by prog_valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= ld_data;
    end

    // Combinational fetch; the operand address wraps DEPTH-1 -> 0.
    always_comb begin
        addr_next     = cpu_addr + ADDR_W'(1);
        cpu_data      = prog_valid ? mem[cpu_addr]  : NOP_CODE;
        cpu_data_next = prog_valid ? mem[addr_next] : NOP_CODE;
        cpu_hold      = !prog_valid;
    end

endmodule

// File: tb/tb_program_memory_loadable.sv
// Scoreboard bench for program_memory_loadable: stimulus pushes expected load results
// and fetch results into queues, a negedge monitor pops and compares them.
module tb_program_memory_loadable;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] cpu_addr = '0;
    logic [7:0] cpu_data, cpu_data_next;
    logic       cpu_hold, prog_valid;
    logic       ld_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [7:0] ld_data = '0;
    logic       ld_done, ld_error;
    logic [8:0] ld_count;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  shadow [256];
    logic        exp_valid = 1'b0;
    logic [31:0] lq[$];
    logic [31:0] fq[$];
    logic [7:0]  img[$];
    logic        fetch_req = 1'b0;
    logic        err_q = 1'b0;

    program_memory_loadable #(.DATA_W(8), .ADDR_W(8), .NOP_CODE(8'h70)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_data_next(cpu_data_next), .cpu_hold(cpu_hold), .prog_valid(prog_valid),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_done(ld_done), .ld_error(ld_error), .ld_count(ld_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: load results on ld_done / rising ld_error, fetch results on fetch_req.
    always @(negedge clk) begin
        if (reset) begin
            if (ld_done || (ld_error && !err_q)) begin
                if (lq.size() == 0) chk("unexpected_load_event", {21'b0, ld_done, ld_error, ld_count}, 32'h0);
                else chk("load_result", {21'b0, ld_done, ld_error, ld_count}, lq.pop_front());
            end
            if (fetch_req) begin
                if (fq.size() == 0) chk("fetch_queue_empty", 32'h1, 32'h0);
                else chk("fetch", {15'b0, cpu_hold, cpu_data, cpu_data_next}, fq.pop_front());
            end
        end
        err_q = ld_error;
    end

    task automatic start_pulse;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        logic acc;
        acc = 1'b0;
        ld_valid = 1'b0;
        repeat (gap) tick();
        ld_valid = 1'b1;
        ld_data  = b;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = ld_ready;
            tick();
        end
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
        if (!acc) chk("ready_timeout", 32'h0, 32'h1);
    endtask

    task automatic fetch(input logic [7:0] a);
        logic [7:0] an;
        an = a + 8'd1;
        cpu_addr  = a;
        fetch_req = 1'b1;
        if (exp_valid) fq.push_back({15'b0, 1'b0, shadow[a], shadow[an]});
        else           fq.push_back({15'b0, 1'b1, 8'h70, 8'h70});
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] a, input logic [7:0] len, input logic [7:0] cs,
                              input logic good, input int unsigned gapmod);
        logic [7:0] p;
        p = a;
        start_pulse();
        send_byte(a, 0);
        send_byte(len, 1);
        foreach (img[i]) begin
            send_byte(img[i], (gapmod != 0 && (i % gapmod) == gapmod - 1) ? 2 : 0);
            shadow[p] = img[i];
            p++;
        end
        lq.push_back({21'b0, good, !good, 9'(img.size())});
        send_byte(cs, 1);
        exp_valid = good;
        chk("prog_valid_at_csum", {31'b0, prog_valid}, {31'b0, good});
        chk("ld_done_at_csum", {31'b0, ld_done}, {31'b0, good});
        for (int i = 0; i < 8 && lq.size() != 0; i++) tick();
        if (lq.size() != 0) begin
            chk("load_event_timeout", lq.size(), 32'h0);
            lq.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // 1: reset state, NOP fetch
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'h0);
        chk("rst_prog_valid", {31'b0, prog_valid}, 32'h0);
        chk("rst_ld_done", {31'b0, ld_done}, 32'h0);
        chk("rst_ld_error", {31'b0, ld_error}, 32'h0);
        chk("rst_ld_count", {23'b0, ld_count}, 32'h0);
        fetch(8'h00);

        // 5: LEN=0 loads all 256 words, data = address, sum 0x7F80 -> CSUM 0x80; with valid gaps
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back(8'(i));
        send_image(8'h00, 8'h00, 8'h80, 1'b1, 7);
        chk("full_ld_count", {23'b0, ld_count}, 32'd256);
        fetch(8'h10);
        fetch(8'hFF);

        // 2: good 3-byte image at 0
        img = '{8'h80, 8'h40, 8'h00};
        send_image(8'h00, 8'h03, 8'h40, 1'b1, 0);
        fetch(8'h00);
        fetch(8'h01);
        fetch(8'h02);

        // 3: bad checksum -> error, NOP everywhere
        send_image(8'h00, 8'h03, 8'h41, 1'b0, 0);
        chk("bad_ld_error", {31'b0, ld_error}, 32'h1);
        for (int a = 0; a < 256; a++) fetch(8'(a));

        // 4: wrap-around image at FE
        img = '{8'h11, 8'h22, 8'h33};
        send_image(8'hFE, 8'h03, 8'h9A, 1'b1, 0);
        fetch(8'hFF);
        fetch(8'hFE);
        fetch(8'h00);

        // 6a: abort after two data bytes; byte presented with ld_start is dropped
        start_pulse();
        send_byte(8'h40, 0);
        send_byte(8'h05, 0);
        send_byte(8'hA1, 0); shadow[8'h40] = 8'hA1;
        send_byte(8'hA2, 0); shadow[8'h41] = 8'hA2;
        ld_valid = 1'b1;
        ld_data  = 8'hEE;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        chk("abort_prog_valid", {31'b0, prog_valid}, 32'h0);
        chk("abort_ld_count", {23'b0, ld_count}, 32'h0);
        chk("abort_ld_ready", {31'b0, ld_ready}, 32'h1);
        img = '{8'h01, 8'h02};
        send_image(8'h40, 8'h02, 8'hFD, 1'b1, 0);
        fetch(8'h41);

        // 6b: reset in the middle of S_DATA
        start_pulse();
        send_byte(8'h80, 0);
        send_byte(8'h04, 0);
        send_byte(8'h55, 0); shadow[8'h80] = 8'h55;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_valid = 1'b0;
        chk("midrst_ld_ready", {31'b0, ld_ready}, 32'h0);
        chk("midrst_prog_valid", {31'b0, prog_valid}, 32'h0);
        chk("midrst_ld_count", {23'b0, ld_count}, 32'h0);
        chk("midrst_cpu_hold", {31'b0, cpu_hold}, 32'h1);
        fetch(8'h80);
        img = '{8'h5A};
        send_image(8'h80, 8'h01, 8'hA6, 1'b1, 0);
        fetch(8'h80);

        tick();
        chk("fetch_queue_drained", fq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
